// File: rtl/uart_tx_fifo_pkg.sv
// Shared definitions for the UART transmit path: drain FSM encoding and timing constants.
// Rx-side blocks are expected to import the same package.
package uart_tx_fifo_pkg;

    typedef enum logic [1:0] {
        S_IDLE    = 2'd0,
        S_ISSUE   = 2'd1,
        S_WAIT_HI = 2'd2,
        S_WAIT_LO = 2'd3
    } tx_state_e;

    // Cycles to wait for buart to raise busy after a strobe before giving up on that byte.
    localparam int WAIT_HI_TIMEOUT = 2;

    localparam int UART_DW = 8;

endpackage

// File: rtl/uart_tx_fifo_if.sv
// Bus-side and buart-side signal bundle of the transmit FIFO.
// master = IO decode / buart model side, slave = uart_tx_fifo.
interface uart_tx_fifo_if
    import uart_tx_fifo_pkg::*;
#(
    parameter int DEPTH = 16
);
    localparam int AW = $clog2(DEPTH);

    // Handshakes: a push is wr high for one cycle and is taken at the clock edge only when
    // full is low (otherwise dropped and overflow set); uart_wr is a one-cycle strobe with
    // uart_data valid in that cycle, issued only while uart_busy is low.
    logic               wr;
    logic [UART_DW-1:0] tx_data;
    logic               flush;
    logic               clr_ovf;
    logic               full;
    logic               empty;
    logic [AW:0]        level;
    logic               overflow;
    logic               idle;
    logic               uart_wr;
    logic [UART_DW-1:0] uart_data;
    logic               uart_busy;
    tx_state_e          fsm_state;

    modport master (
        output wr, tx_data, flush, clr_ovf, uart_busy,
        input  full, empty, level, overflow, idle, uart_wr, uart_data, fsm_state
    );

    modport slave (
        input  wr, tx_data, flush, clr_ovf, uart_busy,
        output full, empty, level, overflow, idle, uart_wr, uart_data, fsm_state
    );

endinterface

// File: rtl/uart_tx_fifo_fifo_ram.sv
// DEPTH x 8 byte storage for the transmit FIFO: synchronous write, asynchronous read.
// Contents are deliberately not reset; pointers and level decide what is valid.
module uart_tx_fifo_fifo_ram
    import uart_tx_fifo_pkg::*;
#(
    parameter int DEPTH = 16,
    parameter int AW    = $clog2(DEPTH)
) (
    input  logic               clk,
    input  logic               i_we,
    input  logic [AW-1:0]      i_waddr,
    input  logic [UART_DW-1:0] i_wdata,
    input  logic [AW-1:0]      i_raddr,
    output logic [UART_DW-1:0] o_rdata
);

    logic [UART_DW-1:0] r_mem [DEPTH];

    always_ff @(posedge clk) begin
        if (i_we) begin
            r_mem[i_waddr] <= i_wdata;
        end
    end

    assign o_rdata = r_mem[i_raddr];

endmodule

// File: rtl/uart_tx_fifo.sv
// Transmit byte FIFO in front of buart: queues bytes from the IO bus and drains them
// one strobe at a time, waiting for buart busy to rise and fall between bytes.
module uart_tx_fifo
    import uart_tx_fifo_pkg::*;
#(
    parameter int DEPTH = 16
) (
    input  logic          clk,
    input  logic          resetq,
    uart_tx_fifo_if.slave bus
);

    localparam int            AW       = $clog2(DEPTH);
    localparam logic [AW:0]   LVL_FULL = (AW+1)'(DEPTH);
    localparam logic [AW:0]   LVL_ONE  = (AW+1)'(1);
    localparam logic [AW-1:0] PTR_ONE  = AW'(1);
    localparam logic [1:0]    TO_LAST  = 2'(WAIT_HI_TIMEOUT - 1);

    logic [AW-1:0]      r_wp;
    logic [AW-1:0]      r_rp;
    logic [AW:0]        r_level;
    logic               r_overflow;
    tx_state_e          r_state;
    logic               r_uart_wr;
    logic [UART_DW-1:0] r_uart_data;
    logic [1:0]         r_to_cnt;

    logic               w_full;
    logic               w_empty;
    logic               w_push;
    logic               w_pop;
    logic [UART_DW-1:0] w_rd_data;

    assign w_full  = (r_level == LVL_FULL);
    assign w_empty = (r_level == '0);
    // Full and empty come from the registered level, so a pop never frees room in its own cycle.
    assign w_push  = bus.wr && !w_full && !bus.flush;
    assign w_pop   = (r_state == S_IDLE) && !w_empty && !bus.uart_busy && !bus.flush;

    uart_tx_fifo_fifo_ram #(
        .DEPTH (DEPTH),
        .AW    (AW)
    ) u_ram (
        .clk     (clk),
        .i_we    (w_push),
        .i_waddr (r_wp),
        .i_wdata (bus.tx_data),
        .i_raddr (r_rp),
        .o_rdata (w_rd_data)
    );

    always_ff @(posedge clk or negedge resetq) begin
        if (!resetq) begin
            r_wp       <= '0;
            r_rp       <= '0;
            r_level    <= '0;
            r_overflow <= 1'b0;
        end else if (bus.flush) begin
            r_wp       <= '0;
            r_rp       <= '0;
            r_level    <= '0;
            r_overflow <= 1'b0;
        end else begin
            if (w_push) begin
                r_wp <= r_wp + PTR_ONE;
            end
            if (w_pop) begin
                r_rp <= r_rp + PTR_ONE;
            end
            if (w_push && !w_pop) begin
                r_level <= r_level + LVL_ONE;
            end else if (!w_push && w_pop) begin
                r_level <= r_level - LVL_ONE;
            end
            // A dropped push outranks a same-cycle clear so the loss is never hidden.
            if (bus.wr && w_full) begin
                r_overflow <= 1'b1;
            end else if (bus.clr_ovf) begin
                r_overflow <= 1'b0;
            end
        end
    end

    // Drain FSM; flush leaves it alone so an in-flight byte always completes.
    always_ff @(posedge clk or negedge resetq) begin
        if (!resetq) begin
            r_state     <= S_IDLE;
            r_uart_wr   <= 1'b0;
            r_uart_data <= '0;
            r_to_cnt    <= '0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    r_uart_wr <= 1'b0;
                    if (w_pop) begin
                        r_uart_wr   <= 1'b1;
                        r_uart_data <= w_rd_data;
                        r_state     <= S_ISSUE;
                    end
                end
                S_ISSUE: begin
                    r_uart_wr <= 1'b0;
                    r_to_cnt  <= '0;
                    r_state   <= S_WAIT_HI;
                end
                S_WAIT_HI: begin
                    r_uart_wr <= 1'b0;
                    if (bus.uart_busy) begin
                        r_state <= S_WAIT_LO;
                    end else if (r_to_cnt == TO_LAST) begin
                        r_state <= S_IDLE;
                    end else begin
                        r_to_cnt <= r_to_cnt + 2'd1;
                    end
                end
                S_WAIT_LO: begin
                    r_uart_wr <= 1'b0;
                    if (!bus.uart_busy) begin
                        r_state <= S_IDLE;
                    end
                end
                default: begin
                    r_uart_wr <= 1'b0;
                    r_state   <= S_IDLE;
                end
            endcase
        end
    end

    assign bus.full      = w_full;
    assign bus.empty     = w_empty;
    assign bus.level     = r_level;
    assign bus.overflow  = r_overflow;
    assign bus.idle      = w_empty && (r_state == S_IDLE) && !bus.uart_busy;
    assign bus.uart_wr   = r_uart_wr;
    assign bus.uart_data = r_uart_data;
    assign bus.fsm_state = r_state;

endmodule
